pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural PC for the RV32I core and sequences each instruction through fetch → execute → PC update.
- Drives the instruction-memory request/acknowledge handshake.
- Holds the fetched instruction stable for decode/execute until execute signals done.
- Selects the next PC from sequential, branch-unit or jump-unit candidates; traps on misaligned targets or fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset release.
- TRAP_VEC, 32'h0000_0100, PC loaded on any trap.
- ACK_TIMEOUT, 15, maximum cycles waiting for imem_ack before a fetch-timeout trap (legal range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  32  current instruction address (feeds iaddr of execute units).
- instr  out  32  latched instruction word.
- instr_valid  out  1  instr/pc valid for execute.
- exec_done  in  1  execute finished; next-PC inputs valid this cycle.
- next_pc_sel  in  2  0 = SEQ, 1 = BRANCH, 2 = JUMP, 3 = reserved (treated as SEQ).
- branch_pc  in  32  resolved next PC from B-type unit (taken target or pc+4).
- jump_pc  in  32  target from JAL/JALR unit.
- halt_req  in  1  request to stop after the current instruction.
- halted  out  1  core stopped.
- trap  out  1  one-cycle trap pulse.
- trap_cause  out  2  0 = none, 1 = misaligned target, 2 = fetch timeout.
- trap_addr  out  32  offending target (misaligned) or pc (timeout).
- retire_cnt  out  32  count of retired instructions.

Behaviour:
- Reset (rst_n low, async):
  - State = S_FETCH, pc = RESET_PC.
  - imem_req, instr_valid, halted, trap all 0.
  - instr = 0, trap_cause = 0, trap_addr = 0, retire_cnt = 0.
  - Reset asserted mid-fetch or mid-execute aborts immediately; no retire, no trap.
- States: S_FETCH, S_EXEC, S_TRAP, S_HALT.
- S_FETCH:
  - imem_req = 1; 8-bit wait counter increments each cycle.
  - imem_ack = 1 → instr <= imem_rdata, instr_valid <= 1, counter cleared, go S_EXEC. imem_req drops the cycle after ack.
  - Counter reaches ACK_TIMEOUT without ack → trap_cause = 2, trap_addr = pc, go S_TRAP.
  - An ack arriving in the same cycle the timeout is reached wins (no trap).
- S_EXEC:
  - instr and instr_valid held stable until exec_done.
  - On exec_done, candidate = pc+4 (SEQ/reserved), branch_pc (BRANCH) or jump_pc (JUMP).
  - candidate[1:0] != 0 → trap_cause = 1, trap_addr = candidate, instruction not retired, go S_TRAP.
  - Otherwise: pc <= candidate, retire_cnt += 1, instr_valid <= 0.
  - Then go S_HALT if halt_req sampled 1 that cycle, else S_FETCH.
  - Minimum throughput: fetch-ack cycle + exec_done cycle = 2 cycles per instruction.
- S_TRAP:
  - Lasts exactly one cycle: trap = 1, pc <= TRAP_VEC, instr_valid = 0.
  - trap_cause/trap_addr hold until the next trap or reset.
  - Next state S_HALT if halt_req = 1, else S_FETCH.
- S_HALT:
  - halted = 1, imem_req = 0; pc frozen.
  - halt_req deasserted → go S_FETCH next cycle (halted = 0 that cycle).
- halt_req during S_FETCH is ignored until the instruction completes; a fetch is never abandoned.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0, no trap).
  - retire_cnt wraps to 0 after 32'hFFFF_FFFF.
- exec_done outside S_EXEC is ignored. imem_ack outside S_FETCH is ignored.

Decomposition:
- Shared package riscv_pkg gets:
  - enum pc_sel_t {PC_SEQ, PC_BRANCH, PC_JUMP, PC_RSVD}
  - enum seq_state_t
  - enum trap_cause_t {TRAP_NONE, TRAP_MISALIGN, TRAP_FETCH_TO}
  - constant INSTR_BYTES = 4
- One sub-module, next_pc_mux: combinational candidate select plus misalignment check. The FSM, counters and registers stay in pc_sequencer.

Test Plan:
- Reset release, imem_ack on the 2nd request cycle with 32'h0000_0013 → imem_addr = 0, instr = 32'h13, instr_valid; exec_done with SEL = SEQ → pc = 4, retire_cnt = 1.
- pc = 32'h40, BRANCH, branch_pc = 32'h20 → next imem_addr = 32'h20; branch_pc = 32'h44 (not taken) → 32'h44.
- JUMP with jump_pc = 32'h102 → trap pulse, trap_cause = 1, trap_addr = 32'h102, pc = 32'h100, retire_cnt unchanged.
- ACK_TIMEOUT = 3, no ack → trap asserted after 3 request cycles, trap_cause = 2, trap_addr = old pc; an ack arriving on cycle 3 instead → no trap.
- halt_req high during S_EXEC → halted the cycle after exec_done, imem_req = 0; drop halt_req → fetch resumes at the updated pc.
- rst_n pulled low while instr_valid = 1 → all outputs return to reset values immediately, retire_cnt = 0, next fetch at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the RV32I core control path.
//   pc_sel_t     : next-PC source select driven by the execute stage
//   seq_state_t  : pc_sequencer FSM states
//   trap_cause_t : trap cause codes reported on trap_cause_o
//   INSTR_BYTES  : size of one instruction word in bytes
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RSVD   = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_TRAP  = 2'd2,
        S_HALT  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_MISALIGN = 2'd1,
        TRAP_FETCH_TO = 2'd2
    } trap_cause_t;

    // A target is legal only if it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// -----------------------------------------------------------------------------
// next_pc_mux
// Combinational next-PC candidate select plus alignment check.
// Ports:
//   pc_i        : current PC
//   sel_i       : next-PC source (pc_sel_t encoding; reserved behaves as SEQ)
//   branch_pc_i : resolved next PC from the branch unit
//   jump_pc_i   : target from the JAL/JALR unit
//   cand_o      : selected candidate next PC
//   misalign_o  : candidate is not word aligned
// -----------------------------------------------------------------------------
module next_pc_mux
    import riscv_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] branch_pc_i,
    input  logic [31:0] jump_pc_i,
    output logic [31:0] cand_o,
    output logic        misalign_o
);

    always_comb begin
        case (pc_sel_t'(sel_i))
            PC_BRANCH: cand_o = branch_pc_i;
            PC_JUMP:   cand_o = jump_pc_i;
            // Sequential and reserved both fall through to pc+4 (wraps mod 2^32).
            default:   cand_o = pc_i + 32'(INSTR_BYTES);
        endcase
        misalign_o = is_misaligned(cand_o);
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the architectural PC and walks each instruction through
// fetch -> execute -> PC update, with trap and halt handling.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   imem_req_o          : instruction fetch request
//   imem_addr_o         : fetch address (always equal to pc_o)
//   imem_ack_i          : fetch data valid this cycle
//   imem_rdata_i        : fetched instruction word
//   pc_o                : current instruction address
//   instr_o             : latched instruction word
//   instr_valid_o       : instr_o/pc_o valid for execute
//   exec_done_i         : execute finished; next-PC inputs valid this cycle
//   next_pc_sel_i       : 0 SEQ, 1 BRANCH, 2 JUMP, 3 reserved (as SEQ)
//   branch_pc_i         : branch unit next PC
//   jump_pc_i           : jump unit target
//   halt_req_i          : stop after the current instruction
//   halted_o            : core stopped
//   trap_o              : one-cycle trap pulse
//   trap_cause_o        : 0 none, 1 misaligned target, 2 fetch timeout
//   trap_addr_o         : offending target or timed-out pc
//   retire_cnt_o        : retired instruction count (wraps)
// -----------------------------------------------------------------------------
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        exec_done_i,
    input  logic [1:0]  next_pc_sel_i,
    input  logic [31:0] branch_pc_i,
    input  logic [31:0] jump_pc_i,
    input  logic        halt_req_i,
    output logic        halted_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] trap_addr_o,
    output logic [31:0] retire_cnt_o
);

    // Wait-counter value on the last permitted request cycle without ack.
    localparam logic [7:0] WaitLast = 8'(ACK_TIMEOUT - 1);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [7:0]  wait_q, wait_d;
    trap_cause_t cause_q, cause_d;
    logic [31:0] taddr_q, taddr_d;
    logic [31:0] retire_q, retire_d;
    logic        req_q, req_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;

    logic [31:0] cand;
    logic        cand_misalign;

    next_pc_mux u_next_pc_mux (
        .pc_i        (pc_q),
        .sel_i       (next_pc_sel_i),
        .branch_pc_i (branch_pc_i),
        .jump_pc_i   (jump_pc_i),
        .cand_o      (cand),
        .misalign_o  (cand_misalign)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        wait_d   = wait_q;
        cause_d  = cause_q;
        taddr_d  = taddr_q;
        retire_d = retire_q;

        case (state_q)
            S_FETCH: begin
                // Straight out of reset the request is still low: this cycle only
                // raises it, so an ack seen now is not a response to anything.
                if (req_q) begin
                    if (imem_ack_i) begin
                        instr_d = imem_rdata_i;
                        valid_d = 1'b1;
                        wait_d  = 8'd0;
                        state_d = S_EXEC;
                    end else if (wait_q == WaitLast) begin
                        cause_d = TRAP_FETCH_TO;
                        taddr_d = pc_q;
                        wait_d  = 8'd0;
                        state_d = S_TRAP;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done_i) begin
                    valid_d = 1'b0;
                    if (cand_misalign) begin
                        cause_d = TRAP_MISALIGN;
                        taddr_d = cand;
                        state_d = S_TRAP;
                    end else begin
                        pc_d     = cand;
                        retire_d = retire_q + 32'd1;
                        state_d  = halt_req_i ? S_HALT : S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                pc_d    = TRAP_VEC;
                state_d = halt_req_i ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (!halt_req_i) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Status outputs are registered copies of the state being entered.
        req_d    = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
        trap_d   = (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            wait_q   <= 8'd0;
            cause_q  <= TRAP_NONE;
            taddr_q  <= 32'd0;
            retire_q <= 32'd0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            wait_q   <= wait_d;
            cause_q  <= cause_d;
            taddr_q  <= taddr_d;
            retire_q <= retire_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign trap_o        = trap_q;
    assign trap_cause_o  = cause_q;
    assign trap_addr_o   = taddr_q;
    assign retire_cnt_o  = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam int          ACK_TO   = 3;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_TRAP  = 2;
    localparam int PH_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  next_pc_sel;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic        halt_req;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_addr;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC    (RESET_PC),
        .TRAP_VEC    (TRAP_VEC),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .pc_o          (pc),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .exec_done_i   (exec_done),
        .next_pc_sel_i (next_pc_sel),
        .branch_pc_i   (branch_pc),
        .jump_pc_i     (jump_pc),
        .halt_req_i    (halt_req),
        .halted_o      (halted),
        .trap_o        (trap),
        .trap_cause_o  (trap_cause),
        .trap_addr_o   (trap_addr),
        .retire_cnt_o  (retire_cnt)
    );

    int checks;
    int failures;

    // Behavioural model
    int          m_phase;
    bit          m_started;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    logic [1:0]  m_cause;
    logic [31:0] m_taddr;
    logic [31:0] m_retire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_FETCH;
        m_started = 1'b0;
        m_wait    = 0;
        m_pc      = RESET_PC;
        m_instr   = 32'd0;
        m_valid   = 1'b0;
        m_cause   = 2'd0;
        m_taddr   = 32'd0;
        m_retire  = 32'd0;
    endtask

    task automatic model_step(input logic ack, input logic [31:0] rdata, input logic done,
                              input logic [1:0] sel, input logic [31:0] bpc,
                              input logic [31:0] jpc, input logic halt);
        logic [31:0] target;
        case (m_phase)
            PH_FETCH: begin
                if (!m_started) begin
                    m_started = 1'b1;
                end else if (ack) begin
                    m_instr = rdata;
                    m_valid = 1'b1;
                    m_wait  = 0;
                    m_phase = PH_EXEC;
                end else if (m_wait + 1 == ACK_TO) begin
                    m_cause = 2'd2;
                    m_taddr = m_pc;
                    m_wait  = 0;
                    m_phase = PH_TRAP;
                end else begin
                    m_wait++;
                end
            end
            PH_EXEC: begin
                if (done) begin
                    if (sel == 2'd1)      target = bpc;
                    else if (sel == 2'd2) target = jpc;
                    else                  target = m_pc + 32'd4;
                    m_valid = 1'b0;
                    if ((target % 4) != 0) begin
                        m_cause = 2'd1;
                        m_taddr = target;
                        m_phase = PH_TRAP;
                    end else begin
                        m_pc     = target;
                        m_retire = m_retire + 32'd1;
                        m_phase  = halt ? PH_HALT : PH_FETCH;
                    end
                end
            end
            PH_TRAP: begin
                m_pc    = TRAP_VEC;
                m_phase = halt ? PH_HALT : PH_FETCH;
            end
            default: begin
                if (!halt) m_phase = PH_FETCH;
            end
        endcase
    endtask

    task automatic compare_all();
        check("imem_req", 32'(imem_req), 32'(m_phase == PH_FETCH && m_started));
        check("imem_addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_phase == PH_HALT));
        check("trap", 32'(trap), 32'(m_phase == PH_TRAP));
        check("trap_cause", 32'(trap_cause), 32'(m_cause));
        check("trap_addr", trap_addr, m_taddr);
        check("retire_cnt", retire_cnt, m_retire);
    endtask

    // One clock: drive inputs now (negedge), advance model at posedge, compare at negedge.
    task automatic cyc(input logic ack, input logic [31:0] rdata, input logic done,
                       input logic [1:0] sel, input logic [31:0] bpc, input logic [31:0] jpc,
                       input logic halt);
        imem_ack    = ack;
        imem_rdata  = rdata;
        exec_done   = done;
        next_pc_sel = sel;
        branch_pc   = bpc;
        jump_pc     = jpc;
        halt_req    = halt;
        @(posedge clk);
        if (rst_n) model_step(ack, rdata, done, sel, bpc, jpc, halt);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic halt);
        cyc(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, halt);
    endtask

    task automatic exec(input logic [1:0] sel, input logic [31:0] bpc, input logic [31:0] jpc,
                        input logic halt);
        cyc(1'b0, 32'd0, 1'b1, sel, bpc, jpc, halt);
    endtask

    // Idle until the model expects an active request, then ack it.
    task automatic fetch_ack(input logic [31:0] rdata);
        int n;
        n = 0;
        while (!(m_phase == PH_FETCH && m_started) && n < 10) begin
            idle(1'b0);
            n++;
        end
        checks++;
        if (n >= 10) begin
            failures++;
            $display("FAIL fetch_wait: no request within %0d cycles", n);
        end
        cyc(1'b1, rdata, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r_bpc;
        logic [31:0] r_jpc;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        exec_done   = 1'b0;
        next_pc_sel = 2'd0;
        branch_pc   = 32'd0;
        jump_pc     = 32'd0;
        halt_req    = 1'b0;
        model_reset();

        @(negedge clk);
        compare_all();
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        rst_n = 1'b1;

        // First fetch: request rises, ack on the second request cycle.
        idle(1'b0);
        check("req_up", 32'(imem_req), 32'd1);
        idle(1'b0);
        cyc(1'b1, 32'h0000_0013, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check("first_instr", instr, 32'h13);
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("req_drop", 32'(imem_req), 32'd0);
        exec(2'd0, 32'd0, 32'd0, 1'b0);
        check("seq_pc", pc, 32'h4);
        check("seq_retire", retire_cnt, 32'd1);

        // Branch taken / not taken from pc 0x40.
        fetch_ack(32'h0000_006f);
        exec(2'd2, 32'd0, 32'h40, 1'b0);
        fetch_ack(32'h0000_0063);
        exec(2'd1, 32'h20, 32'd0, 1'b0);
        check("br_taken", imem_addr, 32'h20);
        fetch_ack(32'h0000_006f);
        exec(2'd2, 32'd0, 32'h40, 1'b0);
        fetch_ack(32'h0000_0063);
        exec(2'd1, 32'h44, 32'd0, 1'b0);
        check("br_not_taken", imem_addr, 32'h44);
        check("br_retire", retire_cnt, 32'd5);

        // Misaligned jump target.
        fetch_ack(32'h0000_0067);
        exec(2'd2, 32'd0, 32'h102, 1'b0);
        check("mis_trap", 32'(trap), 32'd1);
        check("mis_cause", 32'(trap_cause), 32'd1);
        check("mis_addr", trap_addr, 32'h102);
        check("mis_retire", retire_cnt, 32'd5);
        idle(1'b0);
        check("mis_vec", pc, 32'h100);
        check("mis_pulse", 32'(trap), 32'd0);

        // Fetch timeout, then ack on the last permitted cycle.
        idle(1'b0);
        idle(1'b0);
        check("to_not_yet", 32'(trap), 32'd0);
        idle(1'b0);
        check("to_trap", 32'(trap), 32'd1);
        check("to_cause", 32'(trap_cause), 32'd2);
        check("to_addr", trap_addr, 32'h100);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b1, 32'h0000_0033, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check("late_ack_trap", 32'(trap), 32'd0);
        check("late_ack_valid", 32'(instr_valid), 32'd1);
        exec(2'd0, 32'd0, 32'd0, 1'b0);
        check("late_ack_pc", pc, 32'h104);

        // Halt after an instruction, then resume.
        fetch_ack(32'h0000_0013);
        exec(2'd0, 32'd0, 32'd0, 1'b1);
        check("halt_on", 32'(halted), 32'd1);
        check("halt_req_low", 32'(imem_req), 32'd0);
        check("halt_pc", pc, 32'h108);
        idle(1'b1);
        check("halt_hold", 32'(halted), 32'd1);
        idle(1'b0);
        check("halt_off", 32'(halted), 32'd0);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h108);
        cyc(1'b1, 32'h0000_0013, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);

        // pc+4 wraps to zero without trapping.
        exec(2'd2, 32'd0, 32'hFFFF_FFFC, 1'b0);
        fetch_ack(32'h0000_0013);
        exec(2'd0, 32'd0, 32'd0, 1'b0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_trap", 32'(trap), 32'd0);

        // Reset while an instruction is held for execute.
        fetch_ack(32'h1234_5678);
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_retire", retire_cnt, 32'd0);
        check("mid_rst_pc", pc, RESET_PC);
        check("mid_rst_instr", instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        cyc(1'b1, 32'h0000_0093, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check("post_rst_addr", imem_addr, RESET_PC);
        check("post_rst_instr", instr, 32'h93);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                r_bpc = $urandom;
                r_jpc = $urandom;
                if ($urandom_range(0, 3) != 0) r_bpc[1:0] = 2'b00;
                if ($urandom_range(0, 3) != 0) r_jpc[1:0] = 2'b00;
                cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 7,
                    2'($urandom_range(0, 3)), r_bpc, r_jpc, $urandom_range(0, 7) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
